// File: rtl/amp_i2c_pkg.sv
// Shared definitions for the AMP I2C target and master blocks.
package amp_i2c_pkg;

    // Default 7-bit target address
    localparam logic [6:0] DEFAULT_I2C_ADDR = 7'h20;

    // R/W bit values carried in bit 0 of the address byte
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // Value of sda during the ninth clock that means acknowledge
    localparam logic BIT_ACK  = 1'b0;

    // Target protocol states
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } i2c_state_t;

endpackage

// File: rtl/amp_i2c_sync.sv
// Input synchronizers for scl/sda plus a history flop, and the derived
// START, STOP and scl edge strobes (each one clk_in cycle wide).
module amp_i2c_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic resetb,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_hist;
    logic                   sda_hist;
    logic                   scl_s;

    // Synchronizer chains and history flops; idle bus level is high so reset to 1
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync[0] <= scl;
            sda_sync[0] <= sda;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                scl_sync[i] <= scl_sync[i-1];
                sda_sync[i] <= sda_sync[i-1];
            end
            scl_hist <= scl_sync[SYNC_STAGES-1];
            sda_hist <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // Edge and bus-condition strobes compare the newest synchronized value with history
    always_comb begin
        scl_rise  = scl_s & ~scl_hist;
        scl_fall  = ~scl_s & scl_hist;
        start_det = scl_s & scl_hist & sda_hist & ~sda_s;
        stop_det  = scl_s & scl_hist & ~sda_hist & sda_s;
    end

endmodule

// File: rtl/amp_i2c_target.sv
// I2C register-access target: address byte, pointer byte, then write data
// bytes or read data bytes with an auto-incrementing 8-bit pointer.
module amp_i2c_target
    import amp_i2c_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR    = DEFAULT_I2C_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_in,
    input  logic       resetb,
    input  logic       scl,
    inout  wire        sda,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy
);

    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_state_t state, state_next;
    logic [2:0] bit_cnt, bit_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic [7:0] pointer, pointer_next;
    logic       sda_low, sda_low_next;
    logic       ack_on, ack_on_next;
    logic       rw_bit, rw_next;
    logic       busy_next;
    logic       wr_en_next;
    logic [7:0] wr_addr_next;
    logic [7:0] wr_data_next;
    logic [7:0] byte_in;

    amp_i2c_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_in    (clk_in),
        .resetb    (resetb),
        .scl       (scl),
        .sda       (sda),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    // Open drain: only ever pull low; reset clears sda_low asynchronously
    assign sda = sda_low ? 1'b0 : 1'bz;

    // Byte as it will look once the bit being sampled now is shifted in
    assign byte_in = {shift_reg[6:0], sda_s};

    // State and datapath registers
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            pointer   <= '0;
            sda_low   <= 1'b0;
            ack_on    <= 1'b0;
            rw_bit    <= 1'b0;
            busy      <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_addr   <= '0;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            shift_reg <= shift_next;
            pointer   <= pointer_next;
            sda_low   <= sda_low_next;
            ack_on    <= ack_on_next;
            rw_bit    <= rw_next;
            busy      <= busy_next;
            wr_en     <= wr_en_next;
            wr_addr   <= wr_addr_next;
            wr_data   <= wr_data_next;
            rd_addr   <= pointer_next;
        end
    end

    // Next-state and datapath update; STOP and START override every state.
    // ack_on marks the ninth clock: set on the fall after bit 8, cleared on the fall after bit 9.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift_reg;
        pointer_next = pointer;
        sda_low_next = sda_low;
        ack_on_next  = ack_on;
        rw_next      = rw_bit;
        busy_next    = busy;
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr;
        wr_data_next = wr_data;

        if (stop_det) begin
            state_next   = ST_IDLE;
            bit_cnt_next = '0;
            sda_low_next = 1'b0;
            ack_on_next  = 1'b0;
            busy_next    = 1'b0;
        end else if (start_det) begin
            state_next   = ST_ADDR;
            bit_cnt_next = '0;
            sda_low_next = 1'b0;
            ack_on_next  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: ;

                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_next   = byte_in;
                        bit_cnt_next = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_in[7:1] == I2C_ADDR) begin
                                state_next = ST_ADDR_ACK;
                                rw_next    = byte_in[0];
                                busy_next  = 1'b1;
                            end else begin
                                state_next = ST_IDLE;
                                busy_next  = 1'b0;
                            end
                        end
                    end
                end

                ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_next   = byte_in;
                        bit_cnt_next = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (state == ST_PTR) begin
                                pointer_next = byte_in;
                                state_next   = ST_PTR_ACK;
                            end else begin
                                wr_en_next   = 1'b1;
                                wr_addr_next = pointer;
                                wr_data_next = byte_in;
                                state_next   = ST_WDATA_ACK;
                            end
                        end
                    end
                end

                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_on) begin
                            ack_on_next  = 1'b1;
                            sda_low_next = 1'b1;
                        end else begin
                            ack_on_next  = 1'b0;
                            sda_low_next = 1'b0;
                            bit_cnt_next = '0;
                            if (state == ST_ADDR_ACK) begin
                                if (rw_bit == RW_WRITE) begin
                                    state_next = ST_PTR;
                                end else begin
                                    state_next   = ST_RDATA;
                                    shift_next   = rd_data;
                                    sda_low_next = ~rd_data[7];
                                end
                            end else if (state == ST_WDATA_ACK) begin
                                pointer_next = pointer + 8'd1;
                                state_next   = ST_WDATA;
                            end else begin
                                state_next = ST_WDATA;
                            end
                        end
                    end
                end

                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_next = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_next  = ST_RDATA_ACK;
                            ack_on_next = 1'b0;
                        end
                    end else if (scl_fall) begin
                        shift_next   = {shift_reg[6:0], shift_reg[7]};
                        sda_low_next = ~shift_reg[6];
                    end
                end

                ST_RDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_on) begin
                            ack_on_next  = 1'b1;
                            sda_low_next = 1'b0;
                        end else begin
                            ack_on_next  = 1'b0;
                            bit_cnt_next = '0;
                            state_next   = ST_RDATA;
                            shift_next   = rd_data;
                            sda_low_next = ~rd_data[7];
                        end
                    end else if (scl_rise && ack_on) begin
                        if (sda_s == BIT_ACK) begin
                            pointer_next = pointer + 8'd1;
                        end else begin
                            state_next  = ST_IDLE;
                            ack_on_next = 1'b0;
                        end
                    end
                end

                default: state_next = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_amp_i2c_target.sv
// Directed self-checking bench for amp_i2c_target acting as a bit-banged initiator.
module tb_amp_i2c_target;

    localparam int T = 200;

    logic       clk_in = 1'b0;
    logic       resetb;
    logic       scl_drv;
    logic       m_sda_low;
    wire        sda_bus;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;

    int cmp_count  = 0;
    int fail_count = 0;

    logic [7:0] wr_addr_log[$];
    logic [7:0] wr_data_log[$];

    amp_i2c_target #(
        .I2C_ADDR    (7'h20),
        .SYNC_STAGES (2)
    ) dut (
        .clk_in  (clk_in),
        .resetb  (resetb),
        .scl     (scl_drv),
        .sda     (sda_bus),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy)
    );

    pullup pu_sda (sda_bus);
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

    // 100 MHz system clock
    always #5 clk_in = ~clk_in;

    // Register file stand-in: contents are rd_addr - 0x2D, one cycle behind rd_addr
    always @(posedge clk_in) rd_data <= rd_addr - 8'h2D;

    // Log every write strobe, sampled on the inactive edge
    always @(negedge clk_in) begin
        if (wr_en) begin
            wr_addr_log.push_back(wr_addr);
            wr_data_log.push_back(wr_data);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        cmp_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clock_bit(input logic b, output logic r);
        m_sda_low = ~b;
        #(T);
        scl_drv = 1'b1;
        #(T);
        r = sda_bus;
        #(T);
        scl_drv = 1'b0;
        #(T);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0;
        #(T);
        scl_drv = 1'b1;
        #(T);
        m_sda_low = 1'b1;
        #(T);
        scl_drv = 1'b0;
        #(T);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        #(T);
        scl_drv = 1'b1;
        #(T);
        m_sda_low = 1'b0;
        #(T);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
        clock_bit(1'b1, r);
        acked = (r == 1'b0);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, r);
            b[i] = r;
        end
        clock_bit(~ack, r);
    endtask

    // Full write transaction: address byte, pointer, up to three data bytes, STOP
    task automatic applyStimulus(input logic [7:0] addr_byte, input logic [7:0] ptr, input int n_data,
                                 input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                                 output int acks);
        logic       a;
        logic [7:0] d;
        acks = 0;
        i2c_start();
        write_byte(addr_byte, a);
        acks += int'(a);
        write_byte(ptr, a);
        acks += int'(a);
        for (int i = 0; i < n_data; i++) begin
            d = (i == 0) ? d0 : (i == 1) ? d1 : d2;
            write_byte(d, a);
            acks += int'(a);
        end
        i2c_stop();
    endtask

    function automatic logic [31:0] log_entry(input int which, input int idx);
        if (which == 0) return (wr_addr_log.size() > idx) ? {24'h0, wr_addr_log[idx]} : 32'hDEAD;
        return (wr_data_log.size() > idx) ? {24'h0, wr_data_log[idx]} : 32'hDEAD;
    endfunction

    initial begin
        int         acks;
        logic       a;
        logic       r;
        logic [7:0] rb;

        resetb    = 1'b0;
        scl_drv   = 1'b1;
        m_sda_low = 1'b0;
        #100;
        checkOutput("reset_sda", sda_bus, 1'b1);
        checkOutput("reset_wr_en", wr_en, 1'b0);
        checkOutput("reset_wr_addr", wr_addr, 8'h00);
        checkOutput("reset_wr_data", wr_data, 8'h00);
        checkOutput("reset_rd_addr", rd_addr, 8'h00);
        checkOutput("reset_busy", busy, 1'b0);
        resetb = 1'b1;
        #(T);

        $display("[TB] single write 0x18 to 0x40");
        applyStimulus(8'h40, 8'h40, 1, 8'h18, 8'h00, 8'h00, acks);
        checkOutput("w1_acks", acks, 3);
        checkOutput("w1_wr_count", wr_addr_log.size(), 1);
        checkOutput("w1_wr_addr", log_entry(0, 0), 8'h40);
        checkOutput("w1_wr_data", log_entry(1, 0), 8'h18);
        checkOutput("w1_busy_after_stop", busy, 1'b0);

        $display("[TB] block write across pointer wrap");
        wr_addr_log.delete();
        wr_data_log.delete();
        applyStimulus(8'h40, 8'hFE, 3, 8'h01, 8'h02, 8'h03, acks);
        checkOutput("blk_acks", acks, 5);
        checkOutput("blk_wr_count", wr_addr_log.size(), 3);
        checkOutput("blk_addr0", log_entry(0, 0), 8'hFE);
        checkOutput("blk_data0", log_entry(1, 0), 8'h01);
        checkOutput("blk_addr1", log_entry(0, 1), 8'hFF);
        checkOutput("blk_data1", log_entry(1, 1), 8'h02);
        checkOutput("blk_addr2", log_entry(0, 2), 8'h00);
        checkOutput("blk_data2", log_entry(1, 2), 8'h03);

        $display("[TB] pointer write, repeated START, two-byte read");
        wr_addr_log.delete();
        wr_data_log.delete();
        acks = 0;
        i2c_start();
        write_byte(8'h40, a);
        acks += int'(a);
        write_byte(8'h35, a);
        acks += int'(a);
        i2c_start();
        write_byte(8'h41, a);
        acks += int'(a);
        checkOutput("rd_acks", acks, 3);
        checkOutput("rd_busy", busy, 1'b1);
        checkOutput("rd_addr_first", rd_addr, 8'h35);
        read_byte(1'b1, rb);
        checkOutput("rd_byte0", rb, 8'h08);
        checkOutput("rd_addr_second", rd_addr, 8'h36);
        read_byte(1'b0, rb);
        checkOutput("rd_byte1", rb, 8'h09);
        checkOutput("rd_sda_released", sda_bus, 1'b1);
        i2c_stop();
        checkOutput("rd_no_wr", wr_addr_log.size(), 0);
        checkOutput("rd_busy_after_stop", busy, 1'b0);

        $display("[TB] foreign address 0x21");
        applyStimulus(8'h42, 8'h10, 1, 8'h55, 8'h00, 8'h00, acks);
        checkOutput("foreign_acks", acks, 0);
        checkOutput("foreign_no_wr", wr_addr_log.size(), 0);
        checkOutput("foreign_busy", busy, 1'b0);

        $display("[TB] STOP mid-byte, then reset during ACK");
        acks = 0;
        i2c_start();
        write_byte(8'h40, a);
        acks += int'(a);
        write_byte(8'h50, a);
        acks += int'(a);
        for (int i = 0; i < 4; i++) clock_bit(1'b1, r);
        i2c_stop();
        checkOutput("abort_acks", acks, 2);
        checkOutput("abort_no_wr", wr_addr_log.size(), 0);
        checkOutput("abort_busy", busy, 1'b0);
        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            rb = 8'h40;
            clock_bit(rb[i], r);
        end
        m_sda_low = 1'b0;
        #(T);
        checkOutput("ack_driven", sda_bus, 1'b0);
        resetb = 1'b0;
        #1;
        checkOutput("reset_async_release", sda_bus, 1'b1);
        #9;
        checkOutput("rst2_wr_en", wr_en, 1'b0);
        checkOutput("rst2_wr_addr", wr_addr, 8'h00);
        checkOutput("rst2_wr_data", wr_data, 8'h00);
        checkOutput("rst2_rd_addr", rd_addr, 8'h00);
        checkOutput("rst2_busy", busy, 1'b0);
        scl_drv = 1'b1;
        #(T);
        resetb = 1'b1;
        #(T);

        $display("[TB] read after reset starts at pointer 0");
        i2c_start();
        write_byte(8'h41, a);
        checkOutput("post_rst_ack", a, 1'b1);
        read_byte(1'b0, rb);
        checkOutput("post_rst_byte", rb, 8'hD3);
        i2c_stop();
        checkOutput("post_rst_no_wr", wr_addr_log.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
